// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and baud helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD,
        PARITY_MARK,
        PARITY_SPACE
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Whole clock cycles per line bit; any fractional remainder is dropped.
    function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                   input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Line value of the parity bit, given the XOR of all data bits.
    function automatic logic parity_bit(input parity_e mode, input logic data_xor);
        logic bit_v;
        case (mode)
            PARITY_EVEN:  bit_v = data_xor;
            PARITY_ODD:   bit_v = ~data_xor;
            PARITY_MARK:  bit_v = 1'b1;
            PARITY_SPACE: bit_v = 1'b0;
            default:      bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CYCLES_PER_BIT-1 while enabled and flags the
// last cycle of each bit. Shared between the UART transmitter and receiver.
module uart_baud_cnt #(
    parameter int unsigned CYCLES_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int unsigned CNT_W = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = en_i && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise advance and wrap at the end of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = bit_end_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake into a one-entry holding register,
// then start bit, data LSB first, optional parity and 1 or 2 stop bits.
//
// state     | meaning
// ----------+------------------------------------------------------------
// TX_IDLE   | line high, waiting for the holding register to fill
// TX_START  | driving the start bit (low)
// TX_DATA   | driving shifter[0], shifting right at each bit end
// TX_PARITY | driving the parity bit captured at shifter load
// TX_STOP   | driving stop bit(s) high; reload from holding reg if full
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 25_000_000,
    parameter int unsigned BAUD_RATE = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter parity_e     PARITY    = PARITY_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 serial,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned CPB   = cycles_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx: CLK_FREQ/BAUD_RATE must give at least 2 cycles per bit");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx: DATA_BITS must be in 5..9");
    end

    tx_state_e            state_q,     state_d;
    logic [DATA_BITS-1:0] hold_q,      hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 par_q,       par_d;
    logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
    logic                 stop_q,      stop_d;
    logic                 serial_q,    serial_d;
    logic                 tx_done_q,   tx_done_d;

    logic bit_end;
    logic accept;
    logic load;

    uart_baud_cnt #(
        .CYCLES_PER_BIT(CPB)
    ) u_baud_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (state_q != TX_IDLE),
        .clr_i    (state_q == TX_IDLE),
        .bit_end_o(bit_end)
    );

    // Intake is gated only by the registered full flag, so ready never
    // depends combinationally on valid.
    assign accept  = valid && !hold_full_q;
    assign ready   = !hold_full_q;
    assign busy    = (state_q != TX_IDLE);
    assign serial  = serial_q;
    assign tx_done = tx_done_q;

    // Next-state, holding register, shifter and registered line value.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        stop_d      = stop_q;
        tx_done_d   = 1'b0;
        serial_d    = 1'b1;
        load        = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY == PARITY_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d    = 1'b0;
                        tx_done_d = 1'b1;
                        // A waiting byte starts at this same edge: no idle gap.
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = TX_START;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        // load needs hold_full_q and accept needs !hold_full_q, so they never
        // collide on the holding register.
        if (load) begin
            shift_d     = hold_q;
            par_d       = parity_bit(PARITY, ^hold_q);
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        // Line value follows the state being entered so serial stays registered.
        case (state_d)
            TX_START:  serial_d = 1'b0;
            TX_DATA:   serial_d = shift_d[0];
            TX_PARITY: serial_d = par_d;
            default:   serial_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset truncates any frame and drops the held byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_idx_q   <= '0;
            stop_q      <= 1'b0;
            serial_q    <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_idx_q   <= bit_idx_d;
            stop_q      <= stop_d;
            serial_q    <= serial_d;
            tx_done_q   <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default framing, parity modes, two stop bits,
// back-to-back intake and mid-frame reset.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 217;

    logic       clk;
    logic       rst_n;
    logic [7:0] din [6];
    logic [5:0] valid_v;
    logic [5:0] ready_v;
    logic [5:0] serial_v;
    logic [5:0] busy_v;
    logic [5:0] tx_done_v;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx #(.PARITY(PARITY_NONE)) u_none (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .serial(serial_v[0]), .busy(busy_v[0]), .tx_done(tx_done_v[0]));
    uart_tx #(.PARITY(PARITY_EVEN)) u_even (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .valid(valid_v[1]),
        .ready(ready_v[1]), .serial(serial_v[1]), .busy(busy_v[1]), .tx_done(tx_done_v[1]));
    uart_tx #(.PARITY(PARITY_ODD)) u_odd (
        .clk(clk), .rst_n(rst_n), .data_in(din[2]), .valid(valid_v[2]),
        .ready(ready_v[2]), .serial(serial_v[2]), .busy(busy_v[2]), .tx_done(tx_done_v[2]));
    uart_tx #(.PARITY(PARITY_MARK)) u_mark (
        .clk(clk), .rst_n(rst_n), .data_in(din[3]), .valid(valid_v[3]),
        .ready(ready_v[3]), .serial(serial_v[3]), .busy(busy_v[3]), .tx_done(tx_done_v[3]));
    uart_tx #(.PARITY(PARITY_SPACE)) u_space (
        .clk(clk), .rst_n(rst_n), .data_in(din[4]), .valid(valid_v[4]),
        .ready(ready_v[4]), .serial(serial_v[4]), .busy(busy_v[4]), .tx_done(tx_done_v[4]));
    uart_tx #(.STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst_n(rst_n), .data_in(din[5]), .valid(valid_v[5]),
        .ready(ready_v[5]), .serial(serial_v[5]), .busy(busy_v[5]), .tx_done(tx_done_v[5]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One handshake, then every cycle of the frame checked against exp_bits
    // (bit i of exp_bits is line bit i, each lasting CPB cycles).
    task automatic frame(input int idx, input logic [7:0] b, input logic [15:0] exp_bits,
                         input int nbits, input string tag);
        int ser_bad;
        int ctl_bad;
        int done_seen;
        ser_bad   = 0;
        ctl_bad   = 0;
        done_seen = 0;
        @(negedge clk);
        din[idx]     = b;
        valid_v[idx] = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_lo"}, 32'(ready_v[idx]), 32'd0);
        chk({tag, "_serial_still_hi"}, 32'(serial_v[idx]), 32'd1);
        valid_v[idx] = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_back"}, 32'(ready_v[idx]), 32'd1);
        for (int bi = 0; bi < nbits; bi++) begin
            for (int c = 0; c < CPB; c++) begin
                if (serial_v[idx] !== exp_bits[bi]) ser_bad++;
                if (busy_v[idx] !== 1'b1 || ready_v[idx] !== 1'b1) ctl_bad++;
                if (tx_done_v[idx] !== 1'b0) done_seen++;
                @(negedge clk);
            end
        end
        chk({tag, "_serial_bits"}, 32'(ser_bad), 32'd0);
        chk({tag, "_busy_ready_in_frame"}, 32'(ctl_bad), 32'd0);
        chk({tag, "_no_early_done"}, 32'(done_seen), 32'd0);
        chk({tag, "_tx_done"}, 32'(tx_done_v[idx]), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy_v[idx]), 32'd0);
        chk({tag, "_serial_idle"}, 32'(serial_v[idx]), 32'd1);
        @(negedge clk);
        chk({tag, "_tx_done_pulse"}, 32'(tx_done_v[idx]), 32'd0);
    endtask

    logic [7:0] bq [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        logic [9:0] fb;
        logic       rdy_prev;
        logic       exp_ser;
        logic       exp_done;
        logic       exp_busy;
        int acc;
        int pos;
        int started;
        int ser_bad;
        int busy_bad;
        int done_bad;
        int done_cnt;
        int f;
        int bi;

        rst_n   = 1'b0;
        valid_v = '0;
        for (int i = 0; i < 6; i++) din[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_serial", 32'(serial_v), 32'h3f);
        chk("rst_busy", 32'(busy_v), 32'h00);
        chk("rst_tx_done", 32'(tx_done_v), 32'h00);
        chk("rst_ready", 32'(ready_v), 32'h3f);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame(0, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, "none_a5");
        frame(1, 8'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "even_07");
        frame(2, 8'h07, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, "odd_07");
        frame(3, 8'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "mark_07");
        frame(4, 8'h07, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, "space_07");
        frame(5, 8'hFF, {5'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, "stop2_ff");

        // Back-to-back: valid held high; data is scrambled whenever ready=0,
        // so only the value present at an accepting edge may appear on the line.
        acc      = 0;
        pos      = 0;
        started  = 0;
        ser_bad  = 0;
        busy_bad = 0;
        done_bad = 0;
        done_cnt = 0;
        @(negedge clk);
        din[0]     = bq[0];
        valid_v[0] = 1'b1;
        rdy_prev   = ready_v[0];
        for (int cyc = 0; cyc < 6600; cyc++) begin
            @(negedge clk);
            if (valid_v[0] && rdy_prev) acc++;
            if (acc >= 3) valid_v[0] = 1'b0;
            else if (ready_v[0]) din[0] = bq[acc];
            else din[0] = ~bq[acc];
            rdy_prev = ready_v[0];
            if (started == 0 && serial_v[0] === 1'b0) started = 1;
            if (started != 0) begin
                if (pos < 3 * 10 * CPB) begin
                    f        = pos / (10 * CPB);
                    bi       = (pos % (10 * CPB)) / CPB;
                    fb       = {1'b1, bq[f], 1'b0};
                    exp_ser  = fb[bi];
                    exp_busy = 1'b1;
                end else begin
                    exp_ser  = 1'b1;
                    exp_busy = 1'b0;
                end
                exp_done = (pos == 2170 || pos == 4340 || pos == 6510);
                if (pos == 6510) exp_busy = 1'b0;
                if (serial_v[0] !== exp_ser) ser_bad++;
                if (busy_v[0] !== exp_busy) busy_bad++;
                if (tx_done_v[0] !== exp_done) done_bad++;
                if (tx_done_v[0] === 1'b1) done_cnt++;
                pos++;
            end
        end
        chk("b2b_started", 32'(started), 32'd1);
        chk("b2b_accepted", 32'(acc), 32'd3);
        chk("b2b_serial", 32'(ser_bad), 32'd0);
        chk("b2b_busy", 32'(busy_bad), 32'd0);
        chk("b2b_done_timing", 32'(done_bad), 32'd0);
        chk("b2b_done_count", 32'(done_cnt), 32'd3);

        // Mid-frame reset with a second byte waiting in the holding register.
        @(negedge clk);
        din[0]     = 8'h5A;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        @(negedge clk);
        din[0]     = 8'h3C;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        chk("rst_mid_hold_full", 32'(ready_v[0]), 32'd0);
        repeat (400) @(negedge clk);
        chk("rst_mid_busy_before", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_serial", 32'(serial_v[0]), 32'd1);
        chk("rst_mid_ready", 32'(ready_v[0]), 32'd1);
        chk("rst_mid_busy", 32'(busy_v[0]), 32'd0);
        ser_bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (serial_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || tx_done_v[0] !== 1'b0) ser_bad++;
        end
        chk("rst_mid_no_frame", 32'(ser_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
